// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the FSM state encoding, grant encoding and byte-enable constant.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_t;

   localparam int BE_MAX_W = 64;
   localparam logic [BE_MAX_W-1:0] BE_ALL_ONES = {BE_MAX_W{1'b1}};

   // Counter width able to hold 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/bus_timer.sv
// Loadable cycle counter with clear/enable and a terminal-count flag.
// A TIMEOUT of zero disables the terminal count entirely.
module bus_timer
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TW      = cnt_width(TIMEOUT)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          tc
);

   localparam logic [TW-1:0] TERM    = TW'(TIMEOUT);
   localparam logic          ENABLED = (TIMEOUT > 0);

   logic [TW-1:0] count_r;

   // Cycle counter: clear has priority over load, load over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {TW{1'b0}};
      end else if (clr) begin
         count_r <= {TW{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (en) begin
         count_r <= count_r + TW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign tc = ENABLED && (count_r == TERM);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data has priority, fetch is guaranteed a grant after MAX_D_STREAK data wins.
module memory_arbiter
   import riscv_pkg::*;
#(
   parameter int AWIDTH       = 32,
   parameter int DWIDTH       = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [AWIDTH-1:0]   if_addr,
   output logic [DWIDTH-1:0]   if_rdata,
   output logic                if_ack,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DWIDTH/8-1:0] d_be,
   input  logic [AWIDTH-1:0]   d_addr,
   input  logic [DWIDTH-1:0]   d_wdata,
   output logic [DWIDTH-1:0]   d_rdata,
   output logic                d_ack,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DWIDTH/8-1:0] mem_be,
   output logic [AWIDTH-1:0]   mem_addr,
   output logic [DWIDTH-1:0]   mem_wdata,
   input  logic [DWIDTH-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic                stall,
   output logic                bus_err
);

   localparam int BW    = DWIDTH / 8;
   localparam int SW    = cnt_width(MAX_D_STREAK);
   localparam int TMR_W = cnt_width(TIMEOUT);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [BW-1:0] BE_ONES    = BE_ALL_ONES[BW-1:0];

   arb_state_t        state_r, state_s;
   gnt_t              gnt_r, gnt_s;
   logic [SW-1:0]     streak_r, streak_s;
   logic              start_s, finish_s, abort_s, tc_s, tmr_en_s;
   logic [DWIDTH-1:0] resp_data_s;

   logic                if_ack_r, d_ack_r, mem_req_r, mem_we_r, bus_err_r;
   logic [DWIDTH-1:0]   if_rdata_r, d_rdata_r, mem_wdata_r;
   logic [AWIDTH-1:0]   mem_addr_r;
   logic [BW-1:0]       mem_be_r;

   // FSM state, current grant and data-streak registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         gnt_r    <= GNT_I;
         streak_r <= {SW{1'b0}};
      end else begin
         state_r  <= state_s;
         gnt_r    <= gnt_s;
         streak_r <= streak_s;
      end
   end

   // Next-state, grant selection and streak update.
   always_comb begin
      state_s  = state_r;
      gnt_s    = gnt_r;
      streak_s = streak_r;
      start_s  = 1'b0;
      finish_s = 1'b0;
      abort_s  = 1'b0;
      case (state_r)
         IDLE: begin
            // Data wins unless fetch has already lost MAX_D_STREAK times in a row.
            if (d_req && (!if_req || (streak_r != STREAK_MAX))) begin
               gnt_s   = GNT_D;
               state_s = BUSY_D;
               start_s = 1'b1;
               if (if_req) begin
                  streak_s = streak_r + SW'(1);
               end else begin
                  streak_s = {SW{1'b0}};
               end
            end else if (if_req) begin
               gnt_s    = GNT_I;
               state_s  = BUSY_I;
               start_s  = 1'b1;
               streak_s = {SW{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               finish_s = 1'b1;
               state_s  = RESP;
            end else if (tc_s) begin
               abort_s = 1'b1;
               state_s = RESP;
            end else begin
               state_s = state_r;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign tmr_en_s    = (state_r == BUSY_I) || (state_r == BUSY_D);
   assign resp_data_s = (abort_s || mem_we_r) ? {DWIDTH{1'b0}} : mem_rdata;

   bus_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst),
      .clr      (start_s),
      .en       (tmr_en_s),
      .load     (1'b0),
      .load_val ({TMR_W{1'b0}}),
      .tc       (tc_s)
   );

   // Memory payload, response data, ack pulses and sticky timeout flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_be_r    <= {BW{1'b0}};
         mem_addr_r  <= {AWIDTH{1'b0}};
         mem_wdata_r <= {DWIDTH{1'b0}};
         if_rdata_r  <= {DWIDTH{1'b0}};
         d_rdata_r   <= {DWIDTH{1'b0}};
         if_ack_r    <= 1'b0;
         d_ack_r     <= 1'b0;
         bus_err_r   <= 1'b0;
      end else begin
         if_ack_r  <= 1'b0;
         d_ack_r   <= 1'b0;
         bus_err_r <= bus_err_r | abort_s;
         if (start_s) begin
            mem_req_r <= 1'b1;
            if (gnt_s == GNT_D) begin
               mem_addr_r  <= d_addr;
               mem_we_r    <= d_we;
               mem_be_r    <= d_be;
               mem_wdata_r <= d_wdata;
            end else begin
               mem_addr_r <= if_addr;
               mem_we_r   <= 1'b0;
               mem_be_r   <= BE_ONES;
            end
         end else if (finish_s || abort_s) begin
            mem_req_r <= 1'b0;
            if (gnt_r == GNT_D) begin
               d_rdata_r <= resp_data_s;
               d_ack_r   <= 1'b1;
            end else begin
               if_rdata_r <= resp_data_s;
               if_ack_r   <= 1'b1;
            end
         end else begin
            mem_req_r <= mem_req_r;
         end
      end
   end

   assign if_rdata  = if_rdata_r;
   assign if_ack    = if_ack_r;
   assign d_rdata   = d_rdata_r;
   assign d_ack     = d_ack_r;
   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_be    = mem_be_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign bus_err   = bus_err_r;
   assign stall     = (if_req & ~if_ack_r) | (d_req & ~d_ack_r);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: scoreboard of expected acks,
// a simple memory model with programmable wait states, one task per scenario.
module tb_memory_arbiter;

   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_ack, d_req, d_we, d_ack;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be, mem_be;
   logic        mem_req, mem_we, mem_ready, stall, bus_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   bit          fixed_en = 1'b0;
   logic [31:0] fixed_val = 32'h0;
   int          wait_cfg = 0;
   int          busy_cnt;

   memory_arbiter #(
      .AWIDTH(32), .DWIDTH(32), .MAX_D_STREAK(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall(stall), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Memory model: read data derived from address, ready after wait_cfg BUSY cycles.
   assign mem_rdata = fixed_en ? fixed_val : (mem_addr ^ KEY);
   assign mem_ready = mem_req && (wait_cfg >= 0) && (busy_cnt >= wait_cfg);

   always @(posedge clk or negedge rst) begin
      if (!rst) busy_cnt <= 0;
      else if (mem_req) busy_cnt <= busy_cnt + 1;
      else busy_cnt <= 0;
   end

   task automatic test_reset();
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({mem_req, mem_we, if_ack, d_ack, bus_err, stall} !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=000000", {mem_req, mem_we, if_ack, d_ack, bus_err, stall});
      end
      checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
         failures++; $display("FAIL reset_payload got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_be);
      end
      checks++; if ({if_rdata, d_rdata} !== 64'h0) begin
         failures++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, d_rdata);
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); #1;
      checks++; if (mem_req !== 1'b0) begin
         failures++; $display("FAIL reset_idle_memreq got=%b exp=0", mem_req);
      end
   endtask

   task automatic test_fetch_only();
      exp_t e;
      fixed_en = 1'b1; fixed_val = 32'h0050_0093; wait_cfg = 0;
      sb.push_back('{is_d: 1'b0, data: 32'h0050_0093});
      @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0010; #1;
      checks++; if ({stall, mem_req} !== 2'b10) begin
         failures++; $display("FAIL fetch_c0 stall/mem_req got=%b exp=10", {stall, mem_req});
      end
      @(negedge clk); #1;
      checks++; if ({stall, mem_req, mem_we, if_ack} !== 4'b1100 || mem_addr !== 32'h10 || mem_be !== 4'hF) begin
         failures++; $display("FAIL fetch_c1 ctrl got=%b addr=%h be=%h exp=1100/10/f",
                              {stall, mem_req, mem_we, if_ack}, mem_addr, mem_be);
      end
      @(negedge clk); #1;
      e = sb.pop_front();
      checks++; if (if_ack !== 1'b1 || if_rdata !== e.data || stall !== 1'b0) begin
         failures++; $display("FAIL fetch_c2 ack=%b rdata=%h stall=%b exp=1/%h/0", if_ack, if_rdata, stall, e.data);
      end
      @(negedge clk); if_req = 1'b0; #1;
      checks++; if ({if_ack, mem_req} !== 2'b00) begin
         failures++; $display("FAIL fetch_c3 ack/mem_req got=%b exp=00", {if_ack, mem_req});
      end
      fixed_en = 1'b0;
   endtask

   task automatic test_store_and_fetch();
      exp_t e;
      int   d_at = -1, i_at = -1;
      wait_cfg = 0;
      sb.push_back('{is_d: 1'b1, data: 32'h0});
      sb.push_back('{is_d: 1'b0, data: 32'h20 ^ KEY});
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
      @(negedge clk); #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL store_payload req=%b we=%b addr=%h wdata=%h exp=1/1/100/deadbeef",
                              mem_req, mem_we, mem_addr, mem_wdata);
      end
      for (int c = 2; c < 30 && i_at < 0; c++) begin
         @(negedge clk);
         if (d_at >= 0 && c == d_at + 1) begin d_req = 1'b0; d_we = 1'b0; end
         #1;
         if (d_ack === 1'b1) begin
            d_at = c; e = sb.pop_front();
            checks++; if (e.is_d !== 1'b1 || d_rdata !== e.data) begin
               failures++; $display("FAIL store_first who=D exp_is_d=%b rdata=%h exp=%h", e.is_d, d_rdata, e.data);
            end
         end
         if (if_ack === 1'b1) begin
            i_at = c; e = sb.pop_front();
            checks++; if (e.is_d !== 1'b0 || if_rdata !== e.data) begin
               failures++; $display("FAIL store_fetch_second who=I exp_is_d=%b rdata=%h exp=%h", e.is_d, if_rdata, e.data);
            end
         end
      end
      @(negedge clk); if_req = 1'b0;
      checks++; if (d_at != 2 || i_at != d_at + 3) begin
         failures++; $display("FAIL store_fetch_timing d_ack_cycle=%0d if_ack_cycle=%0d exp=2/5", d_at, i_at);
      end
   endtask

   task automatic test_starvation();
      exp_t e;
      int   acks = 0;
      wait_cfg = 0;
      for (int k = 0; k < 4; k++) sb.push_back('{is_d: 1'b1, data: 32'h200 ^ KEY});
      sb.push_back('{is_d: 1'b0, data: 32'h40 ^ KEY});
      sb.push_back('{is_d: 1'b1, data: 32'h200 ^ KEY});
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
      for (int c = 1; c < 60 && acks < 6; c++) begin
         @(negedge clk); #1;
         if (d_ack === 1'b1 || if_ack === 1'b1) begin
            acks++; e = sb.pop_front();
            checks++; if (d_ack !== e.is_d || (e.is_d ? d_rdata : if_rdata) !== e.data) begin
               failures++; $display("FAIL starve_grant_%0d d_ack=%b exp=%b rdata=%h exp=%h", acks, d_ack, e.is_d,
                                    (e.is_d ? d_rdata : if_rdata), e.data);
            end
         end
      end
      @(negedge clk); if_req = 1'b0; d_req = 1'b0;
      checks++; if (acks != 6) begin
         failures++; $display("FAIL starve_count got=%0d exp=6", acks);
         sb.delete();
      end
   endtask

   task automatic test_wait_states();
      exp_t e;
      int   ack_at = -1;
      bit   addr_bad = 1'b0;
      wait_cfg = 5;
      sb.push_back('{is_d: 1'b1, data: 32'h300 ^ KEY});
      @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'h3;
      for (int c = 1; c < 30 && ack_at < 0; c++) begin
         @(negedge clk);
         if (c == 2) begin d_addr = 32'h999; d_wdata = 32'h1234_5678; end
         #1;
         if (mem_req === 1'b1 && mem_addr !== 32'h300) addr_bad = 1'b1;
         if (d_ack === 1'b1) ack_at = c;
      end
      e = sb.pop_front();
      @(negedge clk); d_req = 1'b0;
      checks++; if (ack_at != 7) begin
         failures++; $display("FAIL wait_latency got=%0d exp=7", ack_at);
      end
      checks++; if (addr_bad !== 1'b0 || d_rdata !== e.data) begin
         failures++; $display("FAIL wait_addr_data addr_bad=%b rdata=%h exp=0/%h", addr_bad, d_rdata, e.data);
      end
      wait_cfg = 0;
   endtask

   task automatic test_timeout();
      exp_t e;
      int   req_cycles = 0, ack_at = -1;
      bit   got = 1'b0;
      checks++; if (bus_err !== 1'b0) begin
         failures++; $display("FAIL timeout_pre_err got=%b exp=0", bus_err);
      end
      wait_cfg = -1;
      sb.push_back('{is_d: 1'b0, data: 32'h0});
      @(negedge clk); if_req = 1'b1; if_addr = 32'h50;
      for (int c = 1; c < 40 && ack_at < 0; c++) begin
         @(negedge clk); #1;
         if (mem_req === 1'b1) req_cycles++;
         if (if_ack === 1'b1) ack_at = c;
      end
      e = sb.pop_front();
      @(negedge clk); if_req = 1'b0;
      checks++; if (req_cycles != 9 || ack_at != 10) begin
         failures++; $display("FAIL timeout_timing busy=%0d ack_cycle=%0d exp=9/10", req_cycles, ack_at);
      end
      checks++; if (if_rdata !== e.data || bus_err !== 1'b1) begin
         failures++; $display("FAIL timeout_result rdata=%h err=%b exp=%h/1", if_rdata, bus_err, e.data);
      end
      wait_cfg = 0;
      @(negedge clk); if_req = 1'b1; if_addr = 32'h54;
      for (int c = 1; c < 10 && !got; c++) begin
         @(negedge clk); #1;
         if (if_ack === 1'b1) got = 1'b1;
      end
      @(negedge clk); if_req = 1'b0;
      checks++; if (got !== 1'b1 || if_rdata !== (32'h54 ^ KEY) || bus_err !== 1'b1) begin
         failures++; $display("FAIL timeout_sticky ack=%b rdata=%h err=%b exp=1/%h/1", got, if_rdata, bus_err, 32'h54 ^ KEY);
      end
   endtask

   task automatic test_reset_mid();
      bit stray = 1'b0;
      int ack_at = -1;
      wait_cfg = -1;
      @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h180; d_wdata = 32'hCAFE_F00D; d_be = 4'hF;
      @(negedge clk); #1;
      checks++; if (mem_req !== 1'b1) begin
         failures++; $display("FAIL rstmid_busy mem_req got=%b exp=1", mem_req);
      end
      @(negedge clk); rst = 1'b0; d_req = 1'b0; d_we = 1'b0; #1;
      checks++; if ({mem_req, bus_err, d_ack} !== 3'b000) begin
         failures++; $display("FAIL rstmid_same_cycle req/err/ack got=%b exp=000", {mem_req, bus_err, d_ack});
      end
      @(negedge clk); rst = 1'b1; wait_cfg = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         if (d_ack !== 1'b0 || mem_req !== 1'b0) stray = 1'b1;
      end
      checks++; if (stray !== 1'b0) begin
         failures++; $display("FAIL rstmid_no_ack stray=%b exp=0", stray);
      end
      sb.push_back('{is_d: 1'b0, data: 32'h60 ^ KEY});
      @(negedge clk); if_req = 1'b1; if_addr = 32'h60;
      for (int c = 1; c < 10 && ack_at < 0; c++) begin
         @(negedge clk); #1;
         if (if_ack === 1'b1) ack_at = c;
      end
      @(negedge clk); if_req = 1'b0;
      begin
         exp_t e;
         e = sb.pop_front();
         checks++; if (ack_at != 2 || if_rdata !== e.data) begin
            failures++; $display("FAIL rstmid_fetch ack_cycle=%0d rdata=%h exp=2/%h", ack_at, if_rdata, e.data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_store_and_fetch();
      test_starvation();
      test_wait_states();
      test_timeout();
      test_reset_mid();
      checks++; if (sb.size() != 0) begin
         failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
